// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and iteration helpers for the sequential ALU.
package alu_pkg;

  localparam int OPC_W = 5;

  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPC_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OPC_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OPC_W-1:0] OP_SHR  = 5'b00111;
  localparam logic [OPC_W-1:0] OP_SHRA = 5'b01000;
  localparam logic [OPC_W-1:0] OP_SHL  = 5'b01001;
  localparam logic [OPC_W-1:0] OP_ROR  = 5'b01010;
  localparam logic [OPC_W-1:0] OP_ROL  = 5'b01011;
  localparam logic [OPC_W-1:0] OP_MUL  = 5'b01111;
  localparam logic [OPC_W-1:0] OP_DIV  = 5'b10000;
  localparam logic [OPC_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OPC_W-1:0] OP_NOT  = 5'b10010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One iteration edge per operand bit for both MUL and DIV.
  function automatic int mul_div_iter(input int width);
    return width;
  endfunction

  function automatic logic is_muldiv(input logic [OPC_W-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle between a CPU control unit and the sequential ALU.
interface seq_alu_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) ();

  logic                   start;
  logic [OPC_W-1:0]       opcode;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     result;
  logic                   div_by_zero;

  modport master (
    output start, opcode, a, b,
    input  busy, done, result, div_by_zero
  );

  modport slave (
    input  start, opcode, a, b,
    output busy, done, result, div_by_zero
  );

endinterface

// File: rtl/seq_muldiv_core.sv
// Shared shift/accumulate datapath: radix-2 Booth signed multiply and restoring signed divide,
// one bit per cycle, with sign fix-up presented combinationally while fin is high.
module seq_muldiv_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             fin,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dbz
);

  localparam int ITER = mul_div_iter(WIDTH);
  localparam int CW   = $clog2(ITER + 1);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic signed [WIDTH:0] acc_q, acc_d;
  logic [WIDTH-1:0]      qr_q, qr_d;
  logic [WIDTH-1:0]      m_q, m_d;
  logic [WIDTH-1:0]      a_keep_q, a_keep_d;
  logic                  qm1_q, qm1_d;
  logic                  run_q, run_d;
  logic                  div_q, div_d;
  logic                  qneg_q, qneg_d;
  logic                  rneg_q, rneg_d;
  logic                  dbz_q, dbz_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic signed [WIDTH:0] m_ext;
  logic signed [WIDTH:0] booth_sum;
  logic signed [WIDTH:0] rem_shift;
  logic signed [WIDTH:0] trial;
  logic [WIDTH-1:0]      a_abs, b_abs;
  logic [WIDTH-1:0]      q_fix, r_fix;

  always_comb begin
    a_abs     = a[WIDTH-1] ? (~a + ONE) : a;
    b_abs     = b[WIDTH-1] ? (~b + ONE) : b;
    // Accumulator is one bit wider so subtracting the most-negative multiplicand cannot overflow.
    m_ext     = $signed({m_q[WIDTH-1], m_q});
    case ({qr_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + m_ext;
      2'b10:   booth_sum = acc_q - m_ext;
      default: booth_sum = acc_q;
    endcase
    rem_shift = $signed({acc_q[WIDTH-1:0], qr_q[WIDTH-1]});
    trial     = rem_shift - $signed({1'b0, m_q});

    acc_d    = acc_q;
    qr_d     = qr_q;
    m_d      = m_q;
    a_keep_d = a_keep_q;
    qm1_d    = qm1_q;
    run_d    = run_q;
    div_d    = div_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    dbz_d    = dbz_q;
    cnt_d    = cnt_q;

    if (go) begin
      acc_d    = '0;
      qr_d     = is_div ? a_abs : a;
      m_d      = is_div ? b_abs : b;
      a_keep_d = a;
      qm1_d    = 1'b0;
      run_d    = 1'b1;
      div_d    = is_div;
      qneg_d   = a[WIDTH-1] ^ b[WIDTH-1];
      rneg_d   = a[WIDTH-1];
      dbz_d    = is_div && (b == '0);
      cnt_d    = CW'(ITER);
    end else if (run_q) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CW'(1);
        if (div_q) begin
          if (!trial[WIDTH]) begin
            acc_d = trial;
            qr_d  = {qr_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = rem_shift;
            qr_d  = {qr_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d = $signed({booth_sum[WIDTH], booth_sum[WIDTH:1]});
          qr_d  = {booth_sum[0], qr_q[WIDTH-1:1]};
          qm1_d = qr_q[0];
        end
      end else begin
        run_d = 1'b0;
      end
    end
  end

  always_comb begin
    fin   = run_q && (cnt_q == '0);
    q_fix = qneg_q ? (~qr_q + ONE) : qr_q;
    r_fix = rneg_q ? (~acc_q[WIDTH-1:0] + ONE) : acc_q[WIDTH-1:0];
    hi    = acc_q[WIDTH-1:0];
    lo    = qr_q;
    if (div_q) begin
      if (dbz_q) begin
        hi = a_keep_q;
        lo = '1;
      end else begin
        hi = r_fix;
        lo = q_fix;
      end
    end
    dbz = div_q && dbz_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      qr_q     <= '0;
      m_q      <= '0;
      a_keep_q <= '0;
      qm1_q    <= 1'b0;
      run_q    <= 1'b0;
      div_q    <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dbz_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      qr_q     <= qr_d;
      m_q      <= m_d;
      a_keep_q <= a_keep_d;
      qm1_q    <= qm1_d;
      run_q    <= run_d;
      div_q    <= div_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      dbz_q    <= dbz_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: IDLE/EXEC/DONE control, registered single-cycle ops and
// a shared iterative core for MUL/DIV; the CPU stalls on busy.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic      clk,
  input logic      clear,
  seq_alu_if.slave bus
);

  state_t               state_q, state_d;
  logic [OPC_W-1:0]     op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 dbz_q, dbz_d;

  logic                 accept;
  logic                 md_go;
  logic                 core_fin;
  logic                 core_dbz;
  logic [WIDTH-1:0]     core_hi, core_lo;
  logic [WIDTH-1:0]     alu_lo;
  logic [2*WIDTH-1:0]   rot_r, rot_l;
  logic signed [WIDTH-1:0] a_s;
  logic [SHW-1:0]       sh;

  // A request is only taken while not executing; DONE accepts for back-to-back issue.
  assign accept = bus.start && (state_q != ST_EXEC);
  assign md_go  = accept && is_muldiv(bus.opcode);

  seq_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst    (clear),
    .go     (md_go),
    .is_div (bus.opcode == OP_DIV),
    .a      (bus.a),
    .b      (bus.b),
    .fin    (core_fin),
    .hi     (core_hi),
    .lo     (core_lo),
    .dbz    (core_dbz)
  );

  always_comb begin
    sh    = b_q[SHW-1:0];
    a_s   = $signed(a_q);
    rot_r = {a_q, a_q} >> sh;
    rot_l = {a_q, a_q} << sh;
    alu_lo = '0;
    case (op_q)
      OP_ADD:  alu_lo = a_q + b_q;
      OP_SUB:  alu_lo = a_q - b_q;
      OP_AND:  alu_lo = a_q & b_q;
      OP_OR:   alu_lo = a_q | b_q;
      OP_SHR:  alu_lo = a_q >> sh;
      OP_SHRA: alu_lo = a_s >>> sh;
      OP_SHL:  alu_lo = a_q << sh;
      OP_ROR:  alu_lo = rot_r[WIDTH-1:0];
      OP_ROL:  alu_lo = rot_l[2*WIDTH-1:WIDTH];
      OP_NEG:  alu_lo = ~b_q + {{(WIDTH-1){1'b0}}, 1'b1};
      OP_NOT:  alu_lo = ~b_q;
      default: alu_lo = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    dbz_d    = dbz_q;

    if (accept) begin
      op_d = bus.opcode;
      a_d  = bus.a;
      b_d  = bus.b;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.start) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (!is_muldiv(op_q)) begin
          state_d  = ST_DONE;
          result_d = {{WIDTH{1'b0}}, alu_lo};
          dbz_d    = 1'b0;
        end else if (core_fin) begin
          state_d  = ST_DONE;
          result_d = {core_hi, core_lo};
          dbz_d    = core_dbz;
        end
      end
      ST_DONE: begin
        state_d = bus.start ? ST_EXEC : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

  assign bus.busy        = (state_q == ST_EXEC);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.result      = result_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed scoreboard bench for seq_alu at WIDTH=32 and WIDTH=8.
module tb_seq_alu;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic clear;
  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(32)) bus32 ();
  seq_alu_if #(.WIDTH(8))  bus8 ();

  seq_alu #(.WIDTH(32)) dut32 (.clk(clk), .clear(clear), .bus(bus32));
  seq_alu #(.WIDTH(8))  dut8  (.clk(clk), .clear(clear), .bus(bus8));

  typedef struct {
    string       tag;
    logic [63:0] res;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic get_done(input bit w8);
    return w8 ? bus8.done : bus32.done;
  endfunction

  function automatic logic get_busy(input bit w8);
    return w8 ? bus8.busy : bus32.busy;
  endfunction

  function automatic logic get_dbz(input bit w8);
    return w8 ? bus8.div_by_zero : bus32.div_by_zero;
  endfunction

  function automatic logic [63:0] get_res(input bit w8);
    return w8 ? {48'b0, bus8.result} : bus32.result;
  endfunction

  task automatic drive(input bit w8, input logic st, input logic [4:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (w8) begin
      bus8.start = st; bus8.opcode = op; bus8.a = a[7:0]; bus8.b = b[7:0];
    end else begin
      bus32.start = st; bus32.opcode = op; bus32.a = a; bus32.b = b;
    end
  endtask

  task automatic do_op(input bit w8, input string tag, input logic [4:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] res, input logic dbz, input int lat);
    exp_t e;
    int edges;
    int busy_cyc;
    e.tag = tag; e.res = res; e.dbz = dbz; e.lat = lat;
    sb.push_back(e);
    @(negedge clk);
    drive(w8, 1'b1, op, a, b);
    @(negedge clk);
    drive(w8, 1'b0, op, a, b);
    edges = 0;
    busy_cyc = 0;
    while (!get_done(w8) && edges < 200) begin
      if (get_busy(w8)) busy_cyc++;
      @(negedge clk);
      edges++;
    end
    e = sb.pop_front();
    check({e.tag, " latency"}, 64'(edges), 64'(e.lat));
    check({e.tag, " busy_cycles"}, 64'(busy_cyc), 64'(e.lat));
    check({e.tag, " busy_at_done"}, {63'b0, get_busy(w8)}, 64'd0);
    check({e.tag, " result"}, get_res(w8), e.res);
    check({e.tag, " dbz"}, {63'b0, get_dbz(w8)}, {63'b0, e.dbz});
  endtask

  initial begin
    exp_t e;
    clear = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 5'd0, 32'd0, 32'd0);
    @(negedge clk);
    check("rst busy32", {63'b0, bus32.busy}, 64'd0);
    check("rst done32", {63'b0, bus32.done}, 64'd0);
    check("rst result32", bus32.result, 64'd0);
    check("rst dbz32", {63'b0, bus32.div_by_zero}, 64'd0);
    check("rst done8", {63'b0, bus8.done}, 64'd0);
    check("rst result8", {48'b0, bus8.result}, 64'd0);
    clear = 1'b0;

    do_op(1'b0, "add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'h1, 64'h0, 1'b0, 1);
    do_op(1'b0, "shra", OP_SHRA, 32'h8000_0000, 32'h21, 64'h0000_0000_C000_0000, 1'b0, 1);
    do_op(1'b0, "sub", OP_SUB, 32'd5, 32'd7, 64'h0000_0000_FFFF_FFFE, 1'b0, 1);
    do_op(1'b0, "neg", OP_NEG, 32'h0, 32'd5, 64'h0000_0000_FFFF_FFFB, 1'b0, 1);
    do_op(1'b0, "ror0", OP_ROR, 32'h1234_5678, 32'h20, 64'h0000_0000_1234_5678, 1'b0, 1);
    do_op(1'b0, "ror1", OP_ROR, 32'h0000_0001, 32'h1, 64'h0000_0000_8000_0000, 1'b0, 1);
    do_op(1'b0, "shl31", OP_SHL, 32'h0000_0001, 32'h3F, 64'h0000_0000_8000_0000, 1'b0, 1);
    do_op(1'b0, "mul_m3x7", OP_MUL, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 33);
    do_op(1'b0, "mul_minxmin", OP_MUL, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, 33);
    do_op(1'b0, "div_m7d2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 33);
    do_op(1'b0, "div_7dm2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 1'b0, 33);
    do_op(1'b0, "div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0, 33);
    do_op(1'b0, "div_by_0", OP_DIV, 32'd5, 32'd0, 64'h0000_0005_FFFF_FFFF, 1'b1, 33);

    // MUL in flight, ignored ADD at edge 10, asynchronous clear at edge 20.
    @(negedge clk);
    drive(1'b0, 1'b1, OP_MUL, 32'd3, 32'd5);
    @(negedge clk);
    drive(1'b0, 1'b0, OP_MUL, 32'd3, 32'd5);
    repeat (9) @(negedge clk);
    drive(1'b0, 1'b1, OP_ADD, 32'd1, 32'd1);
    @(negedge clk);
    drive(1'b0, 1'b0, OP_ADD, 32'd1, 32'd1);
    check("ign_start busy", {63'b0, bus32.busy}, 64'd1);
    check("ign_start done", {63'b0, bus32.done}, 64'd0);
    repeat (9) @(negedge clk);
    check("pre_clear busy", {63'b0, bus32.busy}, 64'd1);
    @(posedge clk);
    #2 clear = 1'b1;
    #1;
    check("clr busy", {63'b0, bus32.busy}, 64'd0);
    check("clr done", {63'b0, bus32.done}, 64'd0);
    check("clr result", bus32.result, 64'd0);
    check("clr dbz", {63'b0, bus32.div_by_zero}, 64'd0);
    @(negedge clk);
    clear = 1'b0;
    do_op(1'b0, "rol_after_clr", OP_ROL, 32'h8000_0001, 32'h1, 64'h0000_0000_0000_0003, 1'b0, 1);

    // Back-to-back: NOT then ADD, start held through the first done.
    e.tag = "b2b_not"; e.res = 64'h0000_0000_FFFF_FFFF; e.dbz = 1'b0; e.lat = 1;
    sb.push_back(e);
    e.tag = "b2b_add"; e.res = 64'h0000_0000_0000_0003; e.dbz = 1'b0; e.lat = 1;
    sb.push_back(e);
    @(negedge clk);
    drive(1'b0, 1'b1, OP_NOT, 32'd0, 32'd0);
    @(negedge clk);
    check("b2b c1 busy", {63'b0, bus32.busy}, 64'd1);
    drive(1'b0, 1'b1, OP_ADD, 32'd1, 32'd2);
    @(negedge clk);
    check("b2b c2 done", {62'b0, bus32.done, bus32.busy}, 64'd2);
    e = sb.pop_front();
    check({e.tag, " result"}, bus32.result, e.res);
    @(negedge clk);
    check("b2b c3 busy", {62'b0, bus32.done, bus32.busy}, 64'd1);
    drive(1'b0, 1'b0, OP_ADD, 32'd1, 32'd2);
    @(negedge clk);
    check("b2b c4 done", {62'b0, bus32.done, bus32.busy}, 64'd2);
    e = sb.pop_front();
    check({e.tag, " result"}, bus32.result, e.res);

    do_op(1'b1, "w8_mul_min", OP_MUL, 32'h80, 32'h80, 64'h0000_0000_0000_4000, 1'b0, 9);
    do_op(1'b1, "w8_undef", 5'b11111, 32'h12, 32'h34, 64'h0, 1'b0, 1);
    do_op(1'b1, "w8_div", OP_DIV, 32'hF9, 32'h02, 64'h0000_0000_0000_FFFD, 1'b0, 9);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
